panel_controller: RTL and testbench
===================================

PANEL_CONTROLLER -- requirements
Module: panel_controller

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, both named as the codebase names them.
REQ-002 Port CLK, input, 1: the system clock.
REQ-003 Port RESET, input, 1: synchronous, active-high reset.
REQ-004 Port switches, input, 12: the front-panel switch register, asynchronous to CLK.
REQ-005 Port buttons, input, 6: the front-panel button levels, asynchronous to CLK. Bit 0 = LOADADDR, 1 = DEPOSIT, 2 = EXAMINE, 3 = RUN, 4 = STOP, 5 = STEP.
REQ-006 Port mem_req, output, 1: memory request, held until acknowledged.
REQ-007 Port mem_we, output, 1: memory write enable, valid while mem_req is high.
REQ-008 Port mem_addr, output, 12: memory address, equal to PC while mem_req is high.
REQ-009 Port mem_wdata, output, 12: write data, the switch value captured when the command is accepted.
REQ-010 Port mem_ack, input, 1: single-cycle memory acknowledge.
REQ-011 Port mem_rdata, input, 12: read data, valid in the mem_ack cycle.
REQ-012 Port cpu_run, output, 1: run level to the CPU.
REQ-013 Port cpu_step, output, 1: one-cycle single-instruction pulse to the CPU.
REQ-014 Port cpu_pc, input, 12: live CPU program counter.
REQ-015 Port green, output, 12: address display word.
REQ-016 Port red, output, 12: data display word.
REQ-017 Port yellow, output, 12: status display word.

Function
REQ-018 switches and buttons SHALL each pass through a 2-flop synchronizer; a button command is a rising edge of the synchronized level, giving 3 cycles from pin to command.
REQ-019 When more than one command is present in the same cycle, the highest-priority one SHALL be accepted and the rest discarded. Priority: STOP > LOADADDR > DEPOSIT > EXAMINE > STEP > RUN.
REQ-020 FSM states SHALL be IDLE, WRITE, READ and RUNNING.
REQ-021 Commands are accepted only in IDLE, except STOP, which is accepted in any state.
REQ-022 Any other edge arriving in WRITE, READ or RUNNING SHALL be dropped, not queued.
REQ-023 LOADADDR in IDLE: PC <= synchronized switches; remain in IDLE.
REQ-024 DEPOSIT in IDLE: capture the switches into mem_wdata; go to WRITE with mem_req=1 and mem_we=1 from the next cycle.
REQ-025 In the mem_ack cycle of a WRITE: red <= mem_wdata; PC <= PC+1; go to IDLE. mem_req SHALL be low in the following cycle.
REQ-026 EXAMINE in IDLE: go to READ with mem_req=1 and mem_we=0.
REQ-027 In the mem_ack cycle of a READ: red <= mem_rdata; PC <= PC+1; go to IDLE.
REQ-028 PC SHALL increment modulo 4096 (7777 octal wraps to 0000).
REQ-029 RUN in IDLE: cpu_run=1 from the next cycle; go to RUNNING.
REQ-030 STOP in RUNNING: cpu_run=0 from the next cycle; PC <= cpu_pc; go to IDLE.
REQ-031 STOP in IDLE has no effect.
REQ-032 STOP in WRITE or READ SHALL drop mem_req in the next cycle, leave PC and red unchanged, and return to IDLE. A late mem_ack arriving in IDLE SHALL be ignored.
REQ-033 STEP in IDLE: cpu_step=1 for exactly one cycle; PC <= cpu_pc one cycle later; remain in IDLE.
REQ-034 mem_ack arriving while mem_req is low SHALL be ignored.
REQ-035 green SHALL be cpu_pc in RUNNING and PC in all other states.
REQ-036 yellow SHALL be {cpu_run, busy (WRITE or READ), 4'b0, synchronized buttons[5:0]}.

Reset
REQ-037 On RESET: state=IDLE; PC=0; red=0; mem_req=0; mem_we=0; mem_wdata=0; cpu_run=0; cpu_step=0; synchronizers and edge history cleared.
REQ-038 Reset SHALL take effect mid-transaction, and no button edge SHALL be detected in the first cycle after reset.

Structure
REQ-039 Button index constants, the FSM state encoding and the command-priority order SHALL reside in the shared package pdp8_panel_pkg.
REQ-040 Synchronizer plus rising-edge detection SHALL be one sub-module, panel_edge, parameterized by width and instantiated once for the 6 buttons. The switches use a plain synchronizer.

Verification
REQ-041 LOADADDR with switches=0200, then DEPOSIT with switches=7402 and mem_ack after 2 cycles -> write to 0200 of 7402; red=7402; green=0201.
REQ-042 LOADADDR 7777, then EXAMINE with mem_rdata=1234 -> read at 7777; red=1234; green=0000 (wrap).
REQ-043 DEPOSIT and EXAMINE edges in the same cycle -> exactly one write and no read; EXAMINE pressed during WRITE -> dropped.
REQ-044 RUN, then cpu_pc driven to 0345, then STOP -> cpu_run high while running and low after STOP; green follows cpu_pc; PC=0345 after STOP.
REQ-045 DEPOSIT, then STOP before mem_ack, then a late mem_ack -> mem_req drops; PC and red unchanged; state IDLE.
REQ-046 RESET asserted during READ -> all outputs at reset values the next cycle; a held button produces no command until it is released and pressed again.

Source files
------------

// File: rtl/pdp8_panel_pkg.sv
// Shared definitions for the PDP-8 style front panel: button indices,
// controller states and the command priority used to resolve simultaneous presses.
package pdp8_panel_pkg;

    localparam int BTN_W = 6;
    localparam int SW_W  = 12;

    localparam int BTN_LOADADDR = 0;
    localparam int BTN_DEPOSIT  = 1;
    localparam int BTN_EXAMINE  = 2;
    localparam int BTN_RUN      = 3;
    localparam int BTN_STOP     = 4;
    localparam int BTN_STEP     = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_READ    = 2'd2,
        ST_RUNNING = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_STOP,
        CMD_LOADADDR,
        CMD_DEPOSIT,
        CMD_EXAMINE,
        CMD_STEP,
        CMD_RUN
    } cmd_t;

    // Highest-priority command among this cycle's rising edges; the rest are discarded.
    function automatic cmd_t pick_cmd(input logic [BTN_W-1:0] rise);
        if (rise[BTN_STOP])          return CMD_STOP;
        else if (rise[BTN_LOADADDR]) return CMD_LOADADDR;
        else if (rise[BTN_DEPOSIT])  return CMD_DEPOSIT;
        else if (rise[BTN_EXAMINE])  return CMD_EXAMINE;
        else if (rise[BTN_STEP])     return CMD_STEP;
        else if (rise[BTN_RUN])      return CMD_RUN;
        else                         return CMD_NONE;
    endfunction

endpackage

// File: rtl/panel_edge.sv
// Two-flop synchronizer with rising-edge detection. Edges stay masked until the
// pipeline has refilled after reset, so a level held through reset is not a press.
module panel_edge #(
    parameter int W = 6
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [W-1:0] din,
    output logic [W-1:0] level,
    output logic [W-1:0] rise
);

    logic [W-1:0] s1_q, s1_d;
    logic [W-1:0] s2_q, s2_d;
    logic [W-1:0] prev_q, prev_d;
    logic [1:0]   fill_q, fill_d;

    always_comb begin
        s1_d   = din;
        s2_d   = s1_q;
        prev_d = s2_q;
        fill_d = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
            fill_q <= 2'd0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
            fill_q <= fill_d;
        end
    end

    assign level = s2_q;
    assign rise  = (fill_q == 2'd3) ? (s2_q & ~prev_q) : '0;

endmodule

// File: rtl/panel_controller.sv
// Front-panel controller: turns synchronized button presses into PC loads,
// memory deposit/examine transactions and CPU run/step control.
module panel_controller
    import pdp8_panel_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic [SW_W-1:0]   switches,
    input  logic [BTN_W-1:0]  buttons,
    output logic              mem_req,
    output logic              mem_we,
    output logic [SW_W-1:0]   mem_addr,
    output logic [SW_W-1:0]   mem_wdata,
    input  logic              mem_ack,
    input  logic [SW_W-1:0]   mem_rdata,
    output logic              cpu_run,
    output logic              cpu_step,
    input  logic [SW_W-1:0]   cpu_pc,
    output logic [SW_W-1:0]   green,
    output logic [SW_W-1:0]   red,
    output logic [SW_W-1:0]   yellow,
    output state_t            dbg_state
);

    logic [BTN_W-1:0] btn_level;
    logic [BTN_W-1:0] btn_rise;
    cmd_t             cmd;

    state_t          state_q, state_d;
    logic [SW_W-1:0] sw_s1_q, sw_s1_d;
    logic [SW_W-1:0] sw_s2_q, sw_s2_d;
    logic [SW_W-1:0] pc_q, pc_d;
    logic [SW_W-1:0] red_q, red_d;
    logic [SW_W-1:0] mem_wdata_q, mem_wdata_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic            cpu_run_q, cpu_run_d;
    logic            cpu_step_q, cpu_step_d;
    logic            step_dly_q, step_dly_d;

    panel_edge #(.W(BTN_W)) u_btn_edge (
        .CLK   (CLK),
        .RESET (RESET),
        .din   (buttons),
        .level (btn_level),
        .rise  (btn_rise)
    );

    assign cmd = pick_cmd(btn_rise);

    always_comb begin
        state_d     = state_q;
        sw_s1_d     = switches;
        sw_s2_d     = sw_s1_q;
        pc_d        = pc_q;
        red_d       = red_q;
        mem_wdata_d = mem_wdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        cpu_run_d   = cpu_run_q;
        cpu_step_d  = 1'b0;
        step_dly_d  = cpu_step_q;

        // Pick up the CPU's PC once the stepped instruction has had a cycle to retire.
        if (step_dly_q) begin
            pc_d = cpu_pc;
        end

        case (state_q)
            ST_IDLE: begin
                case (cmd)
                    CMD_LOADADDR: pc_d = sw_s2_q;
                    CMD_DEPOSIT: begin
                        mem_wdata_d = sw_s2_q;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        state_d     = ST_WRITE;
                    end
                    CMD_EXAMINE: begin
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b0;
                        state_d   = ST_READ;
                    end
                    CMD_STEP: cpu_step_d = 1'b1;
                    CMD_RUN: begin
                        cpu_run_d = 1'b1;
                        state_d   = ST_RUNNING;
                    end
                    default: ;
                endcase
            end
            ST_WRITE, ST_READ: begin
                // STOP abandons the access even if the acknowledge lands in the same cycle.
                if (cmd == CMD_STOP) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = ST_IDLE;
                end else if (mem_ack) begin
                    red_d     = (state_q == ST_WRITE) ? mem_wdata_q : mem_rdata;
                    pc_d      = pc_q + 12'd1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_RUNNING: begin
                if (cmd == CMD_STOP) begin
                    cpu_run_d = 1'b0;
                    pc_d      = cpu_pc;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
            pc_q        <= '0;
            red_q       <= '0;
            mem_wdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            cpu_run_q   <= 1'b0;
            cpu_step_q  <= 1'b0;
            step_dly_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sw_s1_q     <= sw_s1_d;
            sw_s2_q     <= sw_s2_d;
            pc_q        <= pc_d;
            red_q       <= red_d;
            mem_wdata_q <= mem_wdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            cpu_run_q   <= cpu_run_d;
            cpu_step_q  <= cpu_step_d;
            step_dly_q  <= step_dly_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = pc_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_run   = cpu_run_q;
    assign cpu_step  = cpu_step_q;
    assign red       = red_q;
    assign green     = (state_q == ST_RUNNING) ? cpu_pc : pc_q;
    assign yellow    = {cpu_run_q, (state_q == ST_WRITE) || (state_q == ST_READ), 4'b0000, btn_level};
    assign dbg_state = state_q;

endmodule

// File: tb/tb_panel_controller.sv
// Bench for panel_controller: a table of single-press commands in IDLE/RUNNING,
// then hand-written memory, run/stop, abort and reset sequences with a transaction scoreboard.
module tb_panel_controller;
    import pdp8_panel_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [11:0] switches;
    logic [5:0]  buttons;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [11:0] mem_wdata;
    logic        mem_ack;
    logic [11:0] mem_rdata;
    logic        cpu_run;
    logic        cpu_step;
    logic [11:0] cpu_pc;
    logic [11:0] green;
    logic [11:0] red;
    logic [11:0] yellow;
    state_t      dbg_state;

    int errors = 0;
    int checks = 0;

    // Scoreboard entries: {we, addr, write data (0 for reads)}.
    logic [24:0] exp_q[$];

    typedef struct {
        logic [5:0]  btns;
        logic [11:0] sw;
        logic [11:0] cpc;
        state_t      st;
        logic        run;
        logic        step;
        logic [11:0] green;
    } vec_t;

    vec_t vecs[8];

    panel_controller dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .switches  (switches),
        .buttons   (buttons),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .cpu_run   (cpu_run),
        .cpu_step  (cpu_step),
        .cpu_pc    (cpu_pc),
        .green     (green),
        .red       (red),
        .yellow    (yellow),
        .dbg_state (dbg_state)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0o required %0o", name, act, exp);
        end
    endtask

    // Drive the press for exactly the synchronizer + edge latency, then release.
    task automatic press(input logic [5:0] mask);
        buttons = mask;
        repeat (3) tick();
        buttons = 6'd0;
    endtask

    task automatic mem_cycle(input int delay, input logic [11:0] rdata);
        int n;
        logic [24:0] act;
        logic [24:0] exp;
        n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL mem_req_timeout: mem_req=%b after %0d cycles, required 1", mem_req, n);
        end else begin
            repeat (delay) tick();
            act = {mem_we, mem_addr, (mem_we ? mem_wdata : 12'd0)};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL mem_txn_unexpected: got %0o with no expected transaction", act);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("FAIL mem_txn: got we/addr/data %0o required %0o", act, exp);
                end
            end
            mem_rdata = rdata;
            mem_ack   = 1'b1;
            tick();
            mem_ack   = 1'b0;
            mem_rdata = 12'd0;
            check("mem_req_drop", mem_req, 1'b0);
        end
    endtask

    initial begin
        int seen;

        vecs[0] = '{6'b000001, 12'o0200, 12'o0000, ST_IDLE,    1'b0, 1'b0, 12'o0200};
        vecs[1] = '{6'b000011, 12'o0300, 12'o0000, ST_IDLE,    1'b0, 1'b0, 12'o0300};
        vecs[2] = '{6'b010001, 12'o0400, 12'o0000, ST_IDLE,    1'b0, 1'b0, 12'o0300};
        vecs[3] = '{6'b101000, 12'o0400, 12'o0055, ST_IDLE,    1'b0, 1'b1, 12'o0055};
        vecs[4] = '{6'b001000, 12'o0400, 12'o0100, ST_RUNNING, 1'b1, 1'b0, 12'o0100};
        vecs[5] = '{6'b000001, 12'o0500, 12'o0100, ST_RUNNING, 1'b1, 1'b0, 12'o0100};
        vecs[6] = '{6'b010000, 12'o0500, 12'o0345, ST_IDLE,    1'b0, 1'b0, 12'o0345};
        vecs[7] = '{6'b010000, 12'o0500, 12'o0777, ST_IDLE,    1'b0, 1'b0, 12'o0345};

        RESET     = 1'b1;
        switches  = 12'd0;
        buttons   = 6'd0;
        mem_ack   = 1'b0;
        mem_rdata = 12'd0;
        cpu_pc    = 12'd0;
        repeat (3) tick();
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_cpu_run", cpu_run, 1'b0);
        check("rst_red", red, 12'd0);
        check("rst_green", green, 12'd0);
        check("rst_yellow", yellow, 12'd0);
        RESET = 1'b0;
        repeat (4) tick();

        for (int i = 0; i < 8; i++) begin
            switches = vecs[i].sw;
            cpu_pc   = vecs[i].cpc;
            tick();
            press(vecs[i].btns);
            check($sformatf("vec%0d_state", i), dbg_state, vecs[i].st);
            check($sformatf("vec%0d_run", i), cpu_run, vecs[i].run);
            check($sformatf("vec%0d_step", i), cpu_step, vecs[i].step);
            check($sformatf("vec%0d_mem_req", i), mem_req, 1'b0);
            check($sformatf("vec%0d_yellow", i), yellow, {vecs[i].run, 1'b0, 4'b0000, vecs[i].btns});
            tick();
            check($sformatf("vec%0d_step_end", i), cpu_step, 1'b0);
            repeat (4) tick();
            check($sformatf("vec%0d_green", i), green, vecs[i].green);
        end

        // Deposit 7402 at 0200 with a two-cycle acknowledge delay.
        switches = 12'o0200;
        press(6'b000001);
        repeat (3) tick();
        switches = 12'o7402;
        exp_q.push_back({1'b1, 12'o0200, 12'o7402});
        press(6'b000010);
        check("dep_state", dbg_state, ST_WRITE);
        check("dep_busy", yellow[10], 1'b1);
        mem_cycle(2, 12'd0);
        check("dep_red", red, 12'o7402);
        check("dep_green", green, 12'o0201);
        check("dep_idle", dbg_state, ST_IDLE);

        // Examine at 7777; PC wraps to 0000.
        switches = 12'o7777;
        press(6'b000001);
        repeat (3) tick();
        exp_q.push_back({1'b0, 12'o7777, 12'd0});
        press(6'b000100);
        check("exa_state", dbg_state, ST_READ);
        check("exa_we", mem_we, 1'b0);
        mem_cycle(1, 12'o1234);
        check("exa_red", red, 12'o1234);
        check("exa_green_wrap", green, 12'o0000);

        // Simultaneous DEPOSIT+EXAMINE, then EXAMINE during WRITE.
        switches = 12'o0011;
        tick();
        press(6'b000110);
        check("pri_state", dbg_state, ST_WRITE);
        check("pri_we", mem_we, 1'b1);
        repeat (3) tick();
        press(6'b000100);
        check("drop_state", dbg_state, ST_WRITE);
        repeat (3) tick();
        exp_q.push_back({1'b1, 12'o0000, 12'o0011});
        mem_cycle(0, 12'd0);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (mem_req === 1'b1) seen++;
        end
        check("drop_no_read", seen, 0);
        check("drop_sb_drained", exp_q.size(), 0);
        check("drop_green", green, 12'o0001);
        check("drop_red", red, 12'o0011);

        // RUN, green follows cpu_pc, STOP loads PC.
        cpu_pc = 12'o0200;
        press(6'b001000);
        check("run_cpu_run", cpu_run, 1'b1);
        check("run_green0", green, 12'o0200);
        cpu_pc = 12'o0345;
        tick();
        check("run_green1", green, 12'o0345);
        repeat (3) tick();
        press(6'b010000);
        check("stop_cpu_run", cpu_run, 1'b0);
        check("stop_state", dbg_state, ST_IDLE);
        cpu_pc = 12'o0111;
        tick();
        check("stop_green_pc", green, 12'o0345);

        // DEPOSIT aborted by STOP, then a late acknowledge.
        switches = 12'o5555;
        tick();
        press(6'b000010);
        check("abort_req", mem_req, 1'b1);
        repeat (3) tick();
        press(6'b010000);
        check("abort_req_drop", mem_req, 1'b0);
        check("abort_state", dbg_state, ST_IDLE);
        mem_rdata = 12'o7777;
        mem_ack   = 1'b1;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 12'd0;
        tick();
        check("abort_red", red, 12'o0011);
        check("abort_green", green, 12'o0345);
        check("abort_late_ack_req", mem_req, 1'b0);
        check("abort_late_ack_state", dbg_state, ST_IDLE);

        // Reset in the middle of a READ with EXAMINE held through it.
        switches = 12'o0100;
        press(6'b000001);
        repeat (3) tick();
        buttons = 6'b000100;
        repeat (3) tick();
        check("rr_state_read", dbg_state, ST_READ);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("rr_state", dbg_state, ST_IDLE);
        check("rr_mem_req", mem_req, 1'b0);
        check("rr_mem_we", mem_we, 1'b0);
        check("rr_mem_wdata", mem_wdata, 12'd0);
        check("rr_red", red, 12'd0);
        check("rr_green", green, 12'd0);
        check("rr_yellow", yellow, 12'd0);
        check("rr_cpu_run", cpu_run, 1'b0);
        check("rr_cpu_step", cpu_step, 1'b0);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (mem_req === 1'b1 || dbg_state !== ST_IDLE) seen++;
        end
        check("rr_held_no_cmd", seen, 0);
        buttons = 6'd0;
        repeat (4) tick();
        exp_q.push_back({1'b0, 12'o0000, 12'd0});
        press(6'b000100);
        mem_cycle(0, 12'o4321);
        check("rr_red_after", red, 12'o4321);
        check("rr_green_after", green, 12'o0001);
        check("sb_final_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
